hb_decim2_mc: RTL

//  Parametrised multi-channel half-band decimate-by-2 FIR; successor to the fixed 19-tap single-channel half-band stage.

---
 rtl/hb_decim2_mc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hb_decim2_mc.sv
// Multi-channel half-band decimate-by-2 FIR: per-channel delay lines feeding one shared,
// time-multiplexed pre-add/MAC engine, with round-half-up, saturation and a bypass path.
module hb_decim2_mc #(
    parameter int DW    = 47,
    parameter int CW    = 16,
    parameter int NTAPS = 19,
    parameter int NCH   = 2,
    parameter int OW    = 48,
    parameter logic [((NTAPS-3)/4+1)*CW-1:0] COEFS =
        {16'h0025, 16'hff17, 16'h035b, 16'hf606, 16'h2765},
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic [CHW-1:0]       in_ch,
    input  logic                 bypass,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic [CHW-1:0]       out_ch,
    output logic                 ovf
);
    localparam int K    = (NTAPS - 3) / 4;
    localparam int PW   = DW + 1;
    localparam int MW   = PW + CW;
    localparam int AW   = DW + CW + 1 + $clog2(K + 2);
    localparam int SW   = (AW > OW) ? AW + 1 : OW + 1;
    localparam int CNTW = (K > 0) ? $clog2(K + 1) : 1;
    localparam logic signed [AW-1:0] RND  = {{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
    localparam logic signed [SW-1:0] SMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    generate
        if (NTAPS < 7 || (NTAPS - 3) % 4 != 0 || NCH < 1) begin : g_bad_cfg
            $error("hb_decim2_mc: NTAPS must be 4K+3 with K>=1 and NCH>=1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_CENTER, S_ROUND} state_t;

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [OW-1:0]   out_data_q, out_data_d;
    logic [CHW-1:0]         out_ch_q, out_ch_d;
    logic                   ovf_q, ovf_d;
    logic signed [DW-1:0]   x_q [NCH][NTAPS];
    logic [NCH-1:0]         phase_q;

    logic                   ch_ok, ph_sel, accept, trig;
    logic signed [DW-1:0]   xs [NTAPS];
    logic signed [CW-1:0]   coef;
    logic signed [PW-1:0]   pre;
    logic signed [MW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext, ctr_ext, rnd;
    logic [OW:0]            sat_rnd, sat_byp;

    // Returns {clipped, value} for a wide signed value squeezed into OW bits.
    function automatic logic [OW:0] sat(input logic signed [SW-1:0] v);
        if (v > SMAX)      sat = {1'b1, SMAX[OW-1:0]};
        else if (v < SMIN) sat = {1'b1, SMIN[OW-1:0]};
        else               sat = {1'b0, v[OW-1:0]};
    endfunction

    always_comb begin
        ch_ok  = 1'b0;
        ph_sel = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (in_ch == CHW'(c)) begin
                ch_ok  = 1'b1;
                ph_sel = phase_q[c];
            end
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready & ch_ok;
    assign trig     = accept & ph_sel;

    always_comb begin
        for (int n = 0; n < NTAPS; n++) xs[n] = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_q == CHW'(c)) xs = x_q[c];
        end
    end

    // Symmetric pair pre-add for side tap i, selected by the MAC counter.
    always_comb begin
        coef = '0;
        pre  = '0;
        for (int i = 0; i <= K; i++) begin
            if (cnt_q == CNTW'(i)) begin
                coef = COEFS[(K-i)*CW +: CW];
                pre  = {xs[2*i][DW-1], xs[2*i]} + {xs[NTAPS-1-2*i][DW-1], xs[NTAPS-1-2*i]};
            end
        end
    end

    assign prod     = pre * coef;
    assign prod_ext = {{(AW-MW){prod[MW-1]}}, prod};
    assign ctr_ext  = {{(AW-DW-CW+2){xs[(NTAPS-1)/2][DW-1]}}, xs[(NTAPS-1)/2], {(CW-2){1'b0}}};
    assign rnd      = (acc_q + RND) >>> (CW - 1);
    assign sat_rnd  = sat({{(SW-AW){rnd[AW-1]}}, rnd});
    assign sat_byp  = sat({{(SW-DW){in_data[DW-1]}}, in_data});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ch_d        = ch_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    if (bypass) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sat_byp[OW-1:0];
                        out_ch_d    = in_ch;
                        ovf_d       = ovf_q | sat_byp[OW];
                    end else begin
                        state_d = S_MAC;
                        cnt_d   = '0;
                        acc_d   = '0;
                        ch_d    = in_ch;
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (cnt_q == CNTW'(K)) state_d = S_CENTER;
                else                   cnt_d   = cnt_q + CNTW'(1);
            end
            S_CENTER: begin
                acc_d   = acc_q + ctr_ext;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                out_valid_d = 1'b1;
                out_data_d  = sat_rnd[OW-1:0];
                out_ch_d    = ch_q;
                ovf_d       = ovf_q | sat_rnd[OW];
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ovf_q       <= ovf_d;
        end
    end

    // Delay lines shift on every accepted sample, bypass or not, so history stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                for (int n = 0; n < NTAPS; n++) x_q[c][n] <= '0;
            phase_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (accept && in_ch == CHW'(c)) begin
                    for (int n = NTAPS-1; n > 0; n--) x_q[c][n] <= x_q[c][n-1];
                    x_q[c][0]  <= in_data;
                    phase_q[c] <= ~phase_q[c];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign ovf       = ovf_q;

endmodule
